// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage : pipeline execute stage.
//
// Purpose
//   Sits between the ID-to-EXE and EXE-to-MEM pipeline registers. Holds a
//   combinational ALU and an iterative multiply/divide unit that owns HI/LO.
//   While a MULT/DIV is in flight it raises `freeze` to hold the upstream
//   stages and sends bubbles downstream.
//
// Configuration
//   MD_BITS_PER_CYCLE : mult/div bits retired per clock (1, 2 or 4).
//                       One op takes N = 32/MD_BITS_PER_CYCLE iteration cycles.
//   EXE_OVERFLOW_TRAP_EN (macro) : when defined, a signed ADD/SUB overflow on a
//                       valid instruction raises ovf_trap and suppresses the
//                       register write. When undefined, ovf_trap is tied low.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   a, b, control       operands and op select (a[4:0] is the shift amount)
//   hilo_rd             00 none, 01 MFHI, 10 MFLO (overrides control)
//   inst                instruction word, 0 = bubble
//   rt_data, dest, reg_write, mem_write, mem_to_reg, is_LB_SB, cache_en
//                       control/data carried to the MEM stage
//   alu_result          ALU / HI / LO result
//   *_out               pass-through copies; write enables gated by bubbles
//   inst_out            instruction word, 0 while freezing
//   freeze              stall request to PC/IF/ID/ID-to-EXE
//   md_busy             mult/div FSM not idle
//   ovf_trap            signed ADD/SUB overflow (optional feature)
// -----------------------------------------------------------------------------
module exe_stage #(
    parameter int MD_BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  control,
    input  logic [1:0]  hilo_rd,
    input  logic [31:0] inst,
    input  logic [31:0] rt_data,
    input  logic [4:0]  dest,
    input  logic        reg_write,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic        is_LB_SB,
    input  logic        cache_en,
    output logic [31:0] alu_result,
    output logic [31:0] rt_data_out,
    output logic [4:0]  dest_out,
    output logic        reg_write_out,
    output logic        mem_write_out,
    output logic        mem_to_reg_out,
    output logic        is_LB_SB_out,
    output logic        cache_en_out,
    output logic [31:0] inst_out,
    output logic        freeze,
    output logic        md_busy,
    output logic        ovf_trap
);
    localparam int N     = 32 / MD_BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    // acc: upper product half / partial remainder; sh: multiplier / quotient
    logic [31:0]      acc_q, acc_d, sh_q, sh_d;
    logic [31:0]      mcand_q, mcand_d, dividend_q, dividend_d;
    logic             is_div_q, is_div_d, neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d, b_zero_q, b_zero_d;

    // ------------------------------------------------------------------ control
    logic inst_valid, md_op, md_start;
    assign inst_valid = |inst;
    assign md_op      = (hilo_rd == 2'b00) && (control[3:2] == 2'b11);
    assign md_start   = (state_q == ST_IDLE) && md_op && inst_valid;
    assign freeze     = md_start || (state_q == ST_BUSY);
    assign md_busy    = (state_q != ST_IDLE);

    // ---------------------------------------------------------------------- ALU
    logic [31:0] sum, diff, alu_core;
    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        alu_core = '0;
        case (control)
            4'd0:    alu_core = sum;
            4'd1:    alu_core = diff;
            4'd2:    alu_core = a & b;
            4'd3:    alu_core = a | b;
            4'd4:    alu_core = a ^ b;
            4'd5:    alu_core = ~(a | b);
            4'd6:    alu_core = {31'd0, ($signed(a) < $signed(b))};
            4'd7:    alu_core = {31'd0, (a < b)};
            4'd8:    alu_core = b << a[4:0];
            4'd9:    alu_core = b >> a[4:0];
            4'd10:   alu_core = $signed(b) >>> a[4:0];
            4'd11:   alu_core = {b[15:0], 16'h0000};
            default: alu_core = '0;   // mult/div ops present 0
        endcase
    end

    always_comb begin
        if (hilo_rd == 2'b01)      alu_result = hi_q;
        else if (hilo_rd == 2'b10) alu_result = lo_q;
        else                       alu_result = alu_core;
    end

`ifdef EXE_OVERFLOW_TRAP_EN
    logic add_ovf, sub_ovf;
    assign add_ovf  = (a[31] == b[31]) && (sum[31] != a[31]);
    assign sub_ovf  = (a[31] != b[31]) && (diff[31] != a[31]);
    assign ovf_trap = inst_valid && (hilo_rd == 2'b00) &&
                      (((control == 4'd0) && add_ovf) || ((control == 4'd1) && sub_ovf));
`else
    assign ovf_trap = 1'b0;
`endif

    // ------------------------------------------------------- pass-through/gating
    assign rt_data_out    = rt_data;
    assign dest_out       = dest;
    assign mem_to_reg_out = mem_to_reg;
    assign is_LB_SB_out   = is_LB_SB;
    assign reg_write_out  = reg_write && inst_valid && !freeze && !md_op && !ovf_trap;
    assign mem_write_out  = mem_write && inst_valid && !freeze;
    assign cache_en_out   = cache_en && inst_valid && !freeze;
    assign inst_out       = freeze ? 32'd0 : inst;

    // ------------------------------------------------- mult/div iteration chain
    // Operands are held as magnitudes; the sign is applied once at the end.
    logic [31:0] acc_s [0:MD_BITS_PER_CYCLE];
    logic [31:0] sh_s  [0:MD_BITS_PER_CYCLE];
    assign acc_s[0] = acc_q;
    assign sh_s[0]  = sh_q;

    for (genvar gi = 0; gi < MD_BITS_PER_CYCLE; gi++) begin : g_step
        logic [32:0] add_sum, rem_sh;
        logic [31:0] acc_o, sh_o;
        always_comb begin
            add_sum = {1'b0, acc_s[gi]} + (sh_s[gi][0] ? {1'b0, mcand_q} : 33'd0);
            rem_sh  = {acc_s[gi], sh_s[gi][31]};
            if (is_div_q) begin
                // restoring step: only subtract when the divisor fits
                if (rem_sh >= {1'b0, mcand_q}) begin
                    acc_o = 32'(rem_sh - {1'b0, mcand_q});
                    sh_o  = {sh_s[gi][30:0], 1'b1};
                end else begin
                    acc_o = rem_sh[31:0];
                    sh_o  = {sh_s[gi][30:0], 1'b0};
                end
            end else begin
                // shift-add step: {carry, acc, sh} >> 1
                acc_o = add_sum[32:1];
                sh_o  = {add_sum[0], sh_s[gi][31:1]};
            end
        end
        assign acc_s[gi+1] = acc_o;
        assign sh_s[gi+1]  = sh_o;
    end

    logic [31:0] acc_n, sh_n, quo, rem;
    logic [63:0] prod_mag, prod;
    assign acc_n    = acc_s[MD_BITS_PER_CYCLE];
    assign sh_n     = sh_s[MD_BITS_PER_CYCLE];
    assign prod_mag = {acc_n, sh_n};
    assign prod     = neg_q ? (~prod_mag + 64'd1) : prod_mag;
    assign quo      = neg_q ? (~sh_n + 32'd1) : sh_n;
    assign rem      = rem_neg_q ? (~acc_n + 32'd1) : acc_n;

    // operand magnitudes for the start cycle; control[0]=0 selects signed
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    assign a_neg = ~control[0] & a[31];
    assign b_neg = ~control[0] & b[31];
    assign a_mag = a_neg ? (~a + 32'd1) : a;
    assign b_mag = b_neg ? (~b + 32'd1) : b;

    // ------------------------------------------------------------------- FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        acc_d      = acc_q;
        sh_d       = sh_q;
        mcand_d    = mcand_q;
        dividend_d = dividend_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        b_zero_d   = b_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (md_start) begin
                    acc_d      = '0;
                    sh_d       = a_mag;
                    mcand_d    = b_mag;
                    dividend_d = a;
                    is_div_d   = control[1];
                    neg_d      = a_neg ^ b_neg;
                    rem_neg_d  = a_neg;
                    b_zero_d   = (b == 32'd0);
                    cnt_d      = '0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                acc_d = acc_n;
                sh_d  = sh_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (!is_div_q) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (b_zero_q) begin
                        hi_d = dividend_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            // frozen instruction is still at the inputs; let it drain unstarted
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            acc_q      <= '0;
            sh_q       <= '0;
            mcand_q    <= '0;
            dividend_q <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            b_zero_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            acc_q      <= acc_d;
            sh_q       <= sh_d;
            mcand_q    <= mcand_d;
            dividend_q <= dividend_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            b_zero_q   <= b_zero_d;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage : self-checking bench for exe_stage.
// Random and directed stimulus checked against a behavioural model that uses
// plain 64-bit arithmetic for MULT/DIV and integer operators for the ALU.
// -----------------------------------------------------------------------------
module tb_exe_stage;
    localparam int MDB  = 1;
    localparam int NCYC = 32 / MDB;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b, inst, rt_data;
    logic [3:0]  control;
    logic [1:0]  hilo_rd;
    logic [4:0]  dest;
    logic        reg_write, mem_write, mem_to_reg, is_LB_SB, cache_en;
    logic [31:0] alu_result, rt_data_out, inst_out;
    logic [4:0]  dest_out;
    logic        reg_write_out, mem_write_out, mem_to_reg_out, is_LB_SB_out, cache_en_out;
    logic        freeze, md_busy, ovf_trap;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] hi_exp = 32'd0;
    logic [31:0] lo_exp = 32'd0;

    always #5 clk = ~clk;

    exe_stage #(.MD_BITS_PER_CYCLE(MDB)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .control(control), .hilo_rd(hilo_rd),
        .inst(inst), .rt_data(rt_data), .dest(dest), .reg_write(reg_write),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .is_LB_SB(is_LB_SB),
        .cache_en(cache_en), .alu_result(alu_result), .rt_data_out(rt_data_out),
        .dest_out(dest_out), .reg_write_out(reg_write_out), .mem_write_out(mem_write_out),
        .mem_to_reg_out(mem_to_reg_out), .is_LB_SB_out(is_LB_SB_out),
        .cache_en_out(cache_en_out), .inst_out(inst_out), .freeze(freeze),
        .md_busy(md_busy), .ovf_trap(ovf_trap)
    );

    task automatic drive(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                         input logic [1:0] hr, input logic [31:0] iv,
                         input logic rw, input logic mw, input logic ce);
        control    = c;
        a          = av;
        b          = bv;
        hilo_rd    = hr;
        inst       = iv;
        reg_write  = rw;
        mem_write  = mw;
        cache_en   = ce;
        mem_to_reg = 1'($urandom_range(0, 1));
        is_LB_SB   = 1'($urandom_range(0, 1));
        rt_data    = $urandom;
        dest       = 5'($urandom);
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] av,
                                           input logic [31:0] bv);
        longint sb;
        int     sh;
        sb = longint'($signed(bv));
        sh = int'(av % 32);
        case (c)
            4'd0:    return av + bv;
            4'd1:    return av - bv;
            4'd2:    return av & bv;
            4'd3:    return av | bv;
            4'd4:    return av ^ bv;
            4'd5:    return ~(av | bv);
            4'd6:    return ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
            4'd7:    return (av < bv) ? 32'd1 : 32'd0;
            4'd8:    return bv << sh;
            4'd9:    return bv >> sh;
            4'd10:   return 32'(sb >>> sh);
            4'd11:   return bv * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [3:0] c, input logic [31:0] av,
                                     input logic [31:0] bv);
        longint r;
        if (c == 4'd0)      r = longint'($signed(av)) + longint'($signed(bv));
        else if (c == 4'd1) r = longint'($signed(av)) - longint'($signed(bv));
        else                return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic model_md(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv);
        longint      sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (c)
            4'd12: begin p = sa * sb; hi_exp = p[63:32]; lo_exp = p[31:0]; end
            4'd13: begin up = {32'd0, av} * {32'd0, bv}; hi_exp = up[63:32]; lo_exp = up[31:0]; end
            4'd14: begin
                if (bv == 32'd0) begin lo_exp = 32'hFFFF_FFFF; hi_exp = av; end
                else begin q = sa / sb; r = sa % sb; lo_exp = q[31:0]; hi_exp = r[31:0]; end
            end
            default: begin
                if (bv == 32'd0) begin lo_exp = 32'hFFFF_FFFF; hi_exp = av; end
                else begin lo_exp = av / bv; hi_exp = av % bv; end
            end
        endcase
    endtask

    // Issue one MULT/DIV, count frozen cycles, check the release cycle.
    task automatic run_md(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv);
        int          n;
        logic [31:0] iv;
        iv = $urandom | 32'd1;
        @(posedge clk); #1;
        drive(c, av, bv, 2'b00, iv, 1'b1, 1'b1, 1'b1);
        #3;
        checks++;
        if (freeze !== 1'b1 || reg_write_out !== 1'b0 || mem_write_out !== 1'b0 ||
            cache_en_out !== 1'b0 || inst_out !== 32'd0 || alu_result !== 32'd0) begin
            fails++;
            $display("FAIL md_start ctrl=%0d: freeze=%b rw=%b mw=%b ce=%b inst=%h alu=%h, want 1 0 0 0 0 0",
                     c, freeze, reg_write_out, mem_write_out, cache_en_out, inst_out, alu_result);
        end
        n = 1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #4;
            if (freeze !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != NCYC + 1) begin
            fails++;
            $display("FAIL md_stall_len ctrl=%0d: got %0d cycles, want %0d", c, n, NCYC + 1);
        end
        checks++;
        if (md_busy !== 1'b1 || reg_write_out !== 1'b0 || inst_out !== iv) begin
            fails++;
            $display("FAIL md_done ctrl=%0d: busy=%b rw=%b inst=%h, want 1 0 %h",
                     c, md_busy, reg_write_out, inst_out, iv);
        end
        model_md(c, av, bv);
        $display("md ctrl=%0d a=%h b=%h stall=%0d exp hi=%h lo=%h", c, av, bv, n, hi_exp, lo_exp);
    endtask

    // MFLO then MFHI, compared with the model's HI/LO.
    task automatic check_hilo(input string tag);
        @(posedge clk); #1;
        drive(4'd2, $urandom, $urandom, 2'b10, $urandom | 32'd1, 1'b1, 1'b0, 1'b0);
        #3;
        checks++;
        if (alu_result !== lo_exp || freeze !== 1'b0 || md_busy !== 1'b0 || reg_write_out !== 1'b1) begin
            fails++;
            $display("FAIL %s_mflo: alu=%h frz=%b busy=%b rw=%b, want %h 0 0 1",
                     tag, alu_result, freeze, md_busy, reg_write_out, lo_exp);
        end
        @(posedge clk); #1;
        drive(4'd3, $urandom, $urandom, 2'b01, $urandom | 32'd1, 1'b1, 1'b0, 1'b0);
        #3;
        checks++;
        if (alu_result !== hi_exp) begin
            fails++;
            $display("FAIL %s_mfhi: alu=%h, want %h", tag, alu_result, hi_exp);
        end
        $display("%s: mflo=%h mfhi=%h", tag, lo_exp, alu_result);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'd0, 32'd3, 32'd4, 2'b00, 32'h1234, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #4;
        checks++;
        if (freeze !== 1'b0 || md_busy !== 1'b0 || ovf_trap !== 1'b0 || alu_result !== 32'd7) begin
            fails++;
            $display("FAIL reset_state: frz=%b busy=%b ovf=%b alu=%h, want 0 0 0 7",
                     freeze, md_busy, ovf_trap, alu_result);
        end
        $display("reset: frz=%b busy=%b alu=%h", freeze, md_busy, alu_result);
        rst = 1'b0;
        hi_exp = 32'd0;
        lo_exp = 32'd0;
        check_hilo("reset_hilo");
    endtask

    task automatic test_add();
        @(posedge clk); #1;
        drive(4'd0, 32'd5, 32'd7, 2'b00, 32'h0000_0020, 1'b1, 1'b0, 1'b0);
        #3;
        checks++;
        if (alu_result !== 32'd12 || reg_write_out !== 1'b1 || freeze !== 1'b0) begin
            fails++;
            $display("FAIL add_basic: alu=%h rw=%b frz=%b, want 0000000c 1 0",
                     alu_result, reg_write_out, freeze);
        end
        $display("add 5+7: alu=%h rw=%b", alu_result, reg_write_out);
    endtask

    task automatic test_alu_random();
        logic [3:0]  c;
        logic [31:0] av, bv, iv, e_alu;
        logic        rw, mw, ce, e_ovf;
        for (int i = 0; i < 60; i++) begin
            c  = 4'($urandom_range(0, 11));
            av = $urandom;
            bv = (i % 4 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            iv = $urandom | 32'd1;
            rw = 1'($urandom_range(0, 1));
            mw = 1'($urandom_range(0, 1));
            ce = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            drive(c, av, bv, 2'b00, iv, rw, mw, ce);
            #3;
            e_alu = ref_alu(c, av, bv);
`ifdef EXE_OVERFLOW_TRAP_EN
            e_ovf = ref_ovf(c, av, bv);
`else
            e_ovf = 1'b0;
`endif
            checks++;
            if (alu_result !== e_alu || ovf_trap !== e_ovf) begin
                fails++;
                $display("FAIL alu_rand ctrl=%0d a=%h b=%h: alu=%h ovf=%b, want %h %b",
                         c, av, bv, alu_result, ovf_trap, e_alu, e_ovf);
            end
            checks++;
            if (reg_write_out !== (rw & ~e_ovf) || mem_write_out !== mw || cache_en_out !== ce ||
                inst_out !== iv || rt_data_out !== rt_data || dest_out !== dest ||
                mem_to_reg_out !== mem_to_reg || is_LB_SB_out !== is_LB_SB || freeze !== 1'b0) begin
                fails++;
                $display("FAIL alu_ctl ctrl=%0d: rw=%b mw=%b ce=%b inst=%h frz=%b, want %b %b %b %h 0",
                         c, reg_write_out, mem_write_out, cache_en_out, inst_out, freeze,
                         rw & ~e_ovf, mw, ce, iv);
            end
            $display("alu ctrl=%0d a=%h b=%h -> %h", c, av, bv, alu_result);
        end
    endtask

    task automatic test_bubble();
        @(posedge clk); #1;
        drive(4'd12, 32'd3, 32'd4, 2'b00, 32'd0, 1'b1, 1'b1, 1'b1);
        #3;
        checks++;
        if (freeze !== 1'b0 || reg_write_out !== 1'b0 || mem_write_out !== 1'b0 ||
            cache_en_out !== 1'b0 || inst_out !== 32'd0 || alu_result !== 32'd0) begin
            fails++;
            $display("FAIL bubble: frz=%b rw=%b mw=%b ce=%b inst=%h alu=%h, want all 0",
                     freeze, reg_write_out, mem_write_out, cache_en_out, inst_out, alu_result);
        end
        @(posedge clk); #1;
        drive(4'd0, 32'd1, 32'd1, 2'b00, 32'd0, 1'b1, 1'b0, 1'b0);
        #3;
        checks++;
        if (md_busy !== 1'b0) begin
            fails++;
            $display("FAIL bubble_nostart: busy=%b, want 0", md_busy);
        end
        $display("bubble: frz=%b busy=%b", freeze, md_busy);
    endtask

    task automatic test_md_directed();
        run_md(4'd12, 32'hFFFF_FFFD, 32'd5);        check_hilo("mult_neg");
        run_md(4'd15, 32'd100, 32'd7);              check_hilo("divu");
        run_md(4'd14, 32'hFFFF_FFF9, 32'd2);        check_hilo("div_neg");
        run_md(4'd14, 32'd9, 32'd0);                check_hilo("div_zero");
        run_md(4'd14, 32'h8000_0000, 32'hFFFF_FFFF); check_hilo("div_ovf");
        run_md(4'd15, 32'hDEAD_BEEF, 32'd0);        check_hilo("divu_zero");
    endtask

    task automatic test_md_random();
        logic [3:0]  c;
        logic [31:0] av, bv;
        for (int i = 0; i < 8; i++) begin
            c  = 4'($urandom_range(12, 15));
            av = $urandom;
            bv = (i == 5) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom);
            run_md(c, av, bv);
            check_hilo("md_rand");
        end
    endtask

    task automatic test_back_to_back();
        run_md(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md(4'd14, 32'd1000, 32'hFFFF_FFF3);
        check_hilo("b2b");
    endtask

    task automatic test_reset_mid_busy();
        @(posedge clk); #1;
        drive(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 2'b00, 32'h55, 1'b1, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        drive(4'd0, 32'd0, 32'd0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0);
        #3;
        checks++;
        if (md_busy !== 1'b1 || freeze !== 1'b1) begin
            fails++;
            $display("FAIL rst_busy_pre: busy=%b frz=%b, want 1 1", md_busy, freeze);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #3;
        checks++;
        if (md_busy !== 1'b0 || freeze !== 1'b0) begin
            fails++;
            $display("FAIL rst_busy_post: busy=%b frz=%b, want 0 0", md_busy, freeze);
        end
        $display("reset mid-busy: busy=%b frz=%b", md_busy, freeze);
        hi_exp = 32'd0;
        lo_exp = 32'd0;
        check_hilo("rst_hilo");
    endtask

    task automatic test_overflow();
        logic e_ovf;
        @(posedge clk); #1;
        drive(4'd0, 32'h7FFF_FFFF, 32'd1, 2'b00, 32'h77, 1'b1, 1'b0, 1'b0);
        #3;
`ifdef EXE_OVERFLOW_TRAP_EN
        e_ovf = 1'b1;
`else
        e_ovf = 1'b0;
`endif
        checks++;
        if (alu_result !== 32'h8000_0000 || ovf_trap !== e_ovf || reg_write_out !== ~e_ovf) begin
            fails++;
            $display("FAIL ovf_add: alu=%h ovf=%b rw=%b, want 80000000 %b %b",
                     alu_result, ovf_trap, reg_write_out, e_ovf, ~e_ovf);
        end
        $display("ovf add: alu=%h ovf=%b rw=%b", alu_result, ovf_trap, reg_write_out);
        @(posedge clk); #1;
        drive(4'd1, 32'h8000_0000, 32'd1, 2'b00, 32'h78, 1'b1, 1'b0, 1'b0);
        #3;
        checks++;
        if (alu_result !== 32'h7FFF_FFFF || ovf_trap !== e_ovf || reg_write_out !== ~e_ovf) begin
            fails++;
            $display("FAIL ovf_sub: alu=%h ovf=%b rw=%b, want 7fffffff %b %b",
                     alu_result, ovf_trap, reg_write_out, e_ovf, ~e_ovf);
        end
        $display("ovf sub: alu=%h ovf=%b rw=%b", alu_result, ovf_trap, reg_write_out);
    endtask

    initial begin
        rst = 1'b1;
        drive(4'd0, 32'd0, 32'd0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_add();
        test_alu_random();
        test_bubble();
        test_md_directed();
        test_md_random();
        test_back_to_back();
        test_reset_mid_busy();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage; consumes the registered outputs of the ID-to-EXE pipeline register and feeds the EXE-to-MEM register.
- Combinational ALU plus an iterative multiply/divide unit that owns the HI/LO registers.
- Generates the pipeline-wide freeze while a MULT/DIV is in flight.

Parameters:
MD_BITS_PER_CYCLE, 1, mult/div bits retired per cycle (legal values 1, 2, 4); N = 32/MD_BITS_PER_CYCLE.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
a  in  32  operand A (shift amount in a[4:0])
b  in  32  operand B
control  in  4  op select
hilo_rd  in  2  00 none, 01 MFHI, 10 MFLO
inst  in  32  instruction word; 0 = bubble
rt_data  in  32  store data
dest  in  5  destination register
reg_write  in  1  register-file write enable
mem_write  in  1  memory write enable
mem_to_reg  in  1  load select
is_LB_SB  in  1  byte access
cache_en  in  1  memory access
alu_result  out  32  result
rt_data_out  out  32  pass-through
dest_out  out  5  pass-through
reg_write_out  out  1  gated pass-through
mem_write_out  out  1  gated pass-through
mem_to_reg_out  out  1  pass-through
is_LB_SB_out  out  1  pass-through
cache_en_out  out  1  gated pass-through
inst_out  out  32  instruction word, or 0 when bubbling
freeze  out  1  stall request to the upstream PC/IF/ID/ID-to-EXE
md_busy  out  1  state != IDLE
ovf_trap  out  1  see Optional Feature

Behaviour:
- Op encoding for control:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed), 7 SLTU; result is 1 or 0
  - 8 SLL, 9 SRL, 10 SRA: shift b by a[4:0]
  - 11 LUI: {b[15:0], 16'h0}
  - 12 MULT, 13 MULTU, 14 DIV, 15 DIVU
- ALU path is combinational, 0-cycle latency. Add/sub wrap modulo 2^32.
- hilo_rd != 00 overrides control: alu_result = HI (01) or LO (10).
- Mult/div ops (control 12-15) with inst != 0 drive alu_result = 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on a mult/div op with inst != 0, latch a/b/signedness, clear counter cnt, go to BUSY. freeze=1 combinationally in this same cycle.
  - BUSY: freeze=1. Each cycle retire MD_BITS_PER_CYCLE bits; shift-add for multiply, restoring for divide; cnt++. When cnt == N-1: write HI/LO at that clock edge and go to DONE.
  - DONE: freeze=0 and no new start (the frozen instruction is still present this cycle). Go to IDLE unconditionally.
- Total stall is N+1 cycles; N=32 gives 33 stall cycles.
- MFHI/MFLO immediately after a mult/div reads the new HI/LO value.
- While freeze=1: reg_write_out, mem_write_out and cache_en_out are forced to 0 and inst_out = 0, so a bubble is sent downstream.
- Mult/div instruction itself: reg_write_out = 0 in all states.
- Multiply results: signed MULT gives the 64-bit two's-complement product; HI = upper 32 bits, LO = lower 32 bits.
- Divide results: LO = quotient, HI = remainder. Signed DIV truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (DIV or DIVU): LO = 32'hFFFFFFFF, HI = dividend.
- Signed overflow, DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
- Reset: state = IDLE, cnt = 0, HI = LO = 0, freeze = 0, md_busy = 0, ovf_trap = 0. Reset mid-BUSY aborts the op and leaves HI/LO = 0. Combinational outputs keep following the inputs during reset.
- inst == 0 (bubble): no FSM start, reg_write_out = mem_write_out = cache_en_out = 0.

Optional Feature:
- Macro EXE_OVERFLOW_TRAP_EN.
- Defined: ADD/SUB signed overflow on a valid instruction sets ovf_trap = 1 for that cycle (combinational) and forces reg_write_out = 0.
- Undefined: ovf_trap is tied to 0, results wrap, and reg_write_out passes through.

Test Plan:
- ADD a=5, b=7, reg_write=1 -> alu_result=12, reg_write_out=1, freeze=0.
- MULT a=32'hFFFFFFFD, b=5, MD_BITS_PER_CYCLE=1 -> freeze high 33 cycles, one DONE cycle, then MFLO=32'hFFFFFFF1 and MFHI=32'hFFFFFFFF.
- DIVU a=100, b=7 -> LO=14, HI=2. DIV a=-7, b=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIV a=9, b=0 -> LO=32'hFFFFFFFF, HI=9. DIV a=32'h80000000, b=32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- Assert rst on BUSY cycle 10 -> next cycle state IDLE, freeze=0; MFHI then reads 0.
- With EXE_OVERFLOW_TRAP_EN: ADD 32'h7FFFFFFF+1 -> ovf_trap=1, reg_write_out=0. Without it: alu_result=32'h80000000, reg_write_out=1.
